// File: rtl/bit_serial_alu.sv
// Bit-serial driver for a one-bit ALU slice: latches operands, processes one bit per clock LSB first.
// Optional BIT_SERIAL_ALU_FLAGS_EN adds zero/overflow flag outputs.
module bit_serial_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainv,
  input  logic             binv,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef BIT_SERIAL_ALU_FLAGS_EN
  output logic             zero,
  output logic             overflow,
`endif
  output logic             carryout
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [WIDTH-2:0]   r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ainv, r_binv, r_c;
  logic [1:0]         r_op;

  logic               w_accept, w_last, w_add;
  logic               w_x, w_y, w_bit, w_cnext;
  logic [WIDTH-1:0]   w_res_nxt;

  assign w_add     = r_op[1];
  assign w_x       = r_a[0] ^ r_ainv;
  assign w_y       = r_b[0] ^ r_binv;
  assign w_cnext   = (w_x & w_y) | (w_x & r_c) | (w_y & r_c);
  assign w_bit     = w_add ? (w_x ^ w_y ^ r_c) : (r_op[0] ? (w_x | w_y) : (w_x & w_y));
  assign w_last    = (r_cnt == CNT_W'(WIDTH-1));
  // Partial result lives in WIDTH-1 bits; the final bit is merged straight into result.
  assign w_res_nxt = {w_bit, r_sh};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_next   = S_RUN;
        w_accept = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_ainv   <= 1'b0;
      r_binv   <= 1'b0;
      r_c      <= 1'b0;
      r_op     <= 2'b00;
      result   <= '0;
      carryout <= 1'b0;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
      zero     <= 1'b0;
      overflow <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_ainv <= ainv;
      r_binv <= binv;
      r_op   <= op;
      r_c    <= op[1] & cin;
      r_cnt  <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_sh  <= w_res_nxt[WIDTH-1:1];
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_add) r_c <= w_cnext;
      if (w_last) begin
        result   <= w_res_nxt;
        carryout <= w_add & w_cnext;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
        zero     <= (w_res_nxt == '0);
        // r_c still holds the carry into the MSB here
        overflow <= w_add & (r_c ^ w_cnext);
`endif
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Randomized self-checking bench for bit_serial_alu against an arithmetic reference model.
module tb_bit_serial_alu;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic         ainv = 1'b0, binv = 1'b0, cin = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carryout;
  logic [W-1:0] result;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
  logic         zero, overflow;
`endif

  int checks = 0, failures = 0;

  logic [W-1:0] o_res;
  logic         o_cout, o_zero, o_ovf, o_to;
  int           o_lat, o_busy;

  bit_serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ainv(ainv), .binv(binv), .op(op), .cin(cin),
    .busy(busy), .done(done), .result(result),
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    .zero(zero), .overflow(overflow),
`endif
    .carryout(carryout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Returns {overflow, carryout, result} from word-level arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mai, input logic mbi,
                                          input logic [1:0] mop, input logic mc);
    logic [W-1:0] x, y, r;
    logic [W:0]   s;
    logic         co, ov;
    x = mai ? ~ma : ma;
    y = mbi ? ~mb : mb;
    co = 1'b0; ov = 1'b0;
    if (mop == 2'b00)      r = x & y;
    else if (mop == 2'b01) r = x | y;
    else begin
      s  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, mc};
      r  = s[W-1:0];
      co = s[W];
      ov = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {ov, co, r};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tai,
                        input logic tbi, input logic [1:0] top, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; ainv = tai; binv = tbi; op = top; cin = tc; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); ainv = ~tai; binv = ~tbi; op = ~top; cin = ~tc;
    o_lat = 0; o_busy = 0; o_to = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (busy) o_busy++;
      if (done) begin
        o_lat = n; o_to = 1'b0; o_res = result; o_cout = carryout;
`ifdef BIT_SERIAL_ALU_FLAGS_EN
        o_zero = zero; o_ovf = overflow;
`else
        o_zero = 1'b0; o_ovf = 1'b0;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, carryout} !== 3'b000) begin failures++; $display("FAIL reset_ctl got=%b exp=000", {busy, done, carryout}); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=00", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add;
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 2'b10, 1'b0);
    checks++; if (o_to !== 1'b0) begin failures++; $display("FAIL add_timeout got=1 exp=0"); end
    checks++; if (o_lat != 9) begin failures++; $display("FAIL add_latency got=%0d exp=9", o_lat); end
    checks++; if (o_busy != 8) begin failures++; $display("FAIL add_busy_cycles got=%0d exp=8", o_busy); end
    checks++; if (o_res !== 8'h10) begin failures++; $display("FAIL add_result got=%h exp=10", o_res); end
    checks++; if (o_cout !== 1'b0) begin failures++; $display("FAIL add_cout got=%b exp=0", o_cout); end
    @(negedge clk);
    checks++; if ({done, result} !== {1'b0, 8'h10}) begin failures++; $display("FAIL add_hold got=%b/%h exp=0/10", done, result); end
  endtask

  task automatic test_sub;
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 2'b10, 1'b1);
    checks++; if ({o_cout, o_res} !== {1'b0, 8'hFE}) begin failures++; $display("FAIL sub1 got=%b/%h exp=0/fe", o_cout, o_res); end
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    checks++; if ({o_zero, o_ovf} !== 2'b00) begin failures++; $display("FAIL sub1_flags got=%b exp=00", {o_zero, o_ovf}); end
`endif
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 2'b11, 1'b1);
    checks++; if ({o_cout, o_res} !== {1'b1, 8'h7F}) begin failures++; $display("FAIL sub2 got=%b/%h exp=1/7f", o_cout, o_res); end
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    checks++; if (o_ovf !== 1'b1) begin failures++; $display("FAIL sub2_ovf got=%b exp=1", o_ovf); end
`endif
  endtask

  task automatic test_logic;
    run_op(8'hF0, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b1);
    checks++; if ({o_cout, o_res} !== {1'b0, 8'h30}) begin failures++; $display("FAIL and got=%b/%h exp=0/30", o_cout, o_res); end
    run_op(8'hAA, 8'h00, 1'b1, 1'b0, 2'b01, 1'b1);
    checks++; if ({o_cout, o_res} !== {1'b0, 8'h55}) begin failures++; $display("FAIL or_ainv got=%b/%h exp=0/55", o_cout, o_res); end
  endtask

  task automatic test_random;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rai, rbi, rc;
    logic [W+1:0] exp;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rop = 2'($urandom);
      rai = 1'($urandom); rbi = 1'($urandom); rc = 1'($urandom);
      exp = model(ra, rb, rai, rbi, rop, rc);
      run_op(ra, rb, rai, rbi, rop, rc);
      checks++;
      if (o_to || o_lat != W+1 || {o_cout, o_res} !== exp[W:0]) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h op=%0d got=%b/%h lat=%0d exp=%b/%h", i, ra, rb, rop, o_cout, o_res, o_lat, exp[W], exp[W-1:0]);
      end
`ifdef BIT_SERIAL_ALU_FLAGS_EN
      checks++;
      if ({o_zero, o_ovf} !== {exp[W-1:0] == '0, exp[W+1]}) begin
        failures++; $display("FAIL rand%0d_flags got=%b exp=%b", i, {o_zero, o_ovf}, {exp[W-1:0] == '0, exp[W+1]});
      end
`endif
    end
  endtask

  task automatic test_start_ignored;
    int dones;
    logic [W-1:0] got;
    dones = 0; got = '0;
    @(negedge clk);
    a = 8'h21; b = 8'h13; ainv = 0; binv = 0; op = 2'b10; cin = 0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      if (done) begin dones++; got = result; end
      if (n >= 3 && n <= 6) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      else start = 1'b0;
      @(negedge clk);
    end
    checks++; if (dones != 1) begin failures++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    checks++; if (got !== 8'h34) begin failures++; $display("FAIL ign_result got=%h exp=34", got); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_no_second got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    a = 8'h55; b = 8'h0F; op = 2'b10; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, carryout, result} !== {3'b000, 8'h00}) begin failures++; $display("FAIL midreset got=%b%b%b/%h exp=000/00", busy, done, carryout, result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL midreset_done got=%0d exp=0", dones); end
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 2'b10, 1'b0);
    checks++; if ({o_to, o_cout, o_res} !== {1'b0, 1'b1, 8'h00}) begin failures++; $display("FAIL post_reset got=%b%b/%h exp=01/00", o_to, o_cout, o_res); end
`ifdef BIT_SERIAL_ALU_FLAGS_EN
    checks++; if (o_zero !== 1'b1) begin failures++; $display("FAIL post_reset_zero got=%b exp=1", o_zero); end
`endif
  endtask

  task automatic test_back_to_back;
    int last, pulses;
    logic prev;
    logic [W+1:0] exp;
    last = -1; pulses = 0; prev = 1'b0;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); ainv = 0; binv = 0; op = 2'b10; cin = 1'b1; start = 1'b1;
    exp = model(a, b, 1'b0, 1'b0, 2'b10, 1'b1);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        checks++; if (prev) begin failures++; $display("FAIL b2b_width cycle=%0d got=2+ exp=1", n); end
        checks++; if (result !== exp[W-1:0]) begin failures++; $display("FAIL b2b_result got=%h exp=%h", result, exp[W-1:0]); end
        if (last >= 0) begin
          checks++; if (n - last != W+2) begin failures++; $display("FAIL b2b_period got=%0d exp=%0d", n - last, W+2); end
        end
        last = n;
      end
      prev = done;
    end
    start = 1'b0;
    checks++; if (pulses < 5) begin failures++; $display("FAIL b2b_pulses got=%0d exp>=5", pulses); end
    repeat (2*(W+2)) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_random;
    test_start_ignored;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
